muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_pkg.sv | 70 +++++++
 rtl/muldiv_step.sv | 21 ++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the op decoder.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // sel_hi picks the upper product half for MULH* and the remainder for REM*;
  // both live in the upper working register.
  typedef struct packed {
    logic is_div;
    logic sel_hi;
    logic signed_a;
    logic signed_b;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [2:0] op);
    op_info_t info;
    info = '0;
    unique case (op)
      OP_MUL: begin
      end
      OP_MULH: begin
        info.sel_hi   = 1'b1;
        info.signed_a = 1'b1;
        info.signed_b = 1'b1;
      end
      OP_MULHSU: begin
        info.sel_hi   = 1'b1;
        info.signed_a = 1'b1;
      end
      OP_MULHU: begin
        info.sel_hi = 1'b1;
      end
      OP_DIV: begin
        info.is_div   = 1'b1;
        info.signed_a = 1'b1;
        info.signed_b = 1'b1;
      end
      OP_DIVU: begin
        info.is_div = 1'b1;
      end
      OP_REM: begin
        info.is_div   = 1'b1;
        info.sel_hi   = 1'b1;
        info.signed_a = 1'b1;
        info.signed_b = 1'b1;
      end
      OP_REMU: begin
        info.is_div = 1'b1;
        info.sel_hi = 1'b1;
      end
    endcase
    return info;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational XLEN+1-bit add/subtract step shared by the shift-add
// multiplier and the restoring divider.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0] a,
  input  logic [XLEN:0] b,
  input  logic          sub,
  output logic [XLEN:0] sum_c,
  output logic          qbit_c
);

  // A non-negative trial difference means the divisor fits: quotient bit 1.
  always_comb begin
    sum_c  = sub ? (a - b) : (a + b);
    qbit_c = ~sum_c[XLEN];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, with valid/ready on both sides.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic            is_div_q, is_div_d;
  logic            sel_hi_q, sel_hi_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_d;
  logic            in_ready_d, out_valid_d, busy_d;

  op_info_t        info_in;
  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf;

  logic [XLEN:0]   step_a, step_b, step_sum;
  logic            step_sub, step_qbit;

  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] dsel, div_fix;

  // Request decode: operand magnitudes and the overflow/zero-divisor shortcuts.
  always_comb begin
    info_in     = decode_op(op);
    sa          = info_in.signed_a & operandA[XLEN-1];
    sb          = info_in.signed_b & operandB[XLEN-1];
    a_mag       = sa ? -operandA : operandA;
    b_mag       = sb ? -operandB : operandB;
    div_by_zero = info_in.is_div && (operandB == '0);
    div_ovf     = info_in.is_div && info_in.signed_a &&
                  (operandA == INT_MIN) && (operandB == '1);
  end

  // Divide: trial-subtract divisor from {rem, next dividend bit}.
  // Multiply: conditionally add the multiplicand into the upper half.
  always_comb begin
    if (is_div_q) begin
      step_a   = {hi_q, lo_q[XLEN-1]};
      step_b   = {1'b0, mcand_q};
      step_sub = 1'b1;
    end else begin
      step_a   = {1'b0, hi_q};
      step_b   = lo_q[0] ? {1'b0, mcand_q} : '0;
      step_sub = 1'b0;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .a      (step_a),
    .b      (step_b),
    .sub    (step_sub),
    .sum_c  (step_sum),
    .qbit_c (step_qbit)
  );

  // Sign fix-up applied once the magnitude computation is complete.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    dsel     = sel_hi_q ? hi_q : lo_q;
    div_fix  = neg_q ? -dsel : dsel;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    result_d = result;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (div_by_zero) begin
            result_d = info_in.sel_hi ? operandA : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = info_in.sel_hi ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            is_div_d = info_in.is_div;
            sel_hi_d = info_in.sel_hi;
            neg_d    = (info_in.is_div && info_in.sel_hi) ? sa : (sa ^ sb);
            mcand_d  = info_in.is_div ? b_mag : a_mag;
            lo_d     = info_in.is_div ? a_mag : b_mag;
            hi_d     = '0;
            count_d  = '0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          hi_d = step_qbit ? step_sum[XLEN-1:0] : step_a[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], step_qbit};
        end else begin
          hi_d = step_sum[XLEN:1];
          lo_d = {step_sum[0], lo_q[XLEN-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          result_d = div_fix;
        end else begin
          result_d = sel_hi_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase

    if (flush) begin
      state_d = IDLE;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_q     <= 1'b0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      sel_hi_q  <= sel_hi_d;
      neg_q     <= neg_d;
      result    <= result_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle handshake
// expectations, directed RV32M cases and randomized operations.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int LAT_NORMAL = 34;
  localparam int LAT_SPECIAL = 1;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int tests;
  int fails;
  int rst_cnt;
  bit checking;

  // reference model state
  bit          m_pending;
  int          m_cyc;
  int          m_ready_at;
  logic [31:0] m_res;
  int          m_rst_seen;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operandA  (operandA),
    .operandB  (operandB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    if (o[2] && b == 0) return 1'b1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic model_sync_reset();
    if (rst_cnt != m_rst_seen) begin
      m_pending  = 1'b0;
      m_rst_seen = rst_cnt;
    end
  endtask

  // Model advances at each rising edge from the inputs; outputs compared at the falling edge.
  initial begin
    bit valid_before;
    m_pending  = 1'b0;
    m_cyc      = 0;
    m_ready_at = 0;
    m_res      = '0;
    m_rst_seen = 0;
    forever begin
      @(posedge clk);
      model_sync_reset();
      if (!rst_n) begin
        m_pending = 1'b0;
      end else begin
        m_cyc++;
        valid_before = m_pending && (m_cyc - 1 >= m_ready_at);
        if (flush) begin
          m_pending = 1'b0;
        end else if (!m_pending) begin
          if (in_valid) begin
            m_pending  = 1'b1;
            m_res      = ref_result(op, operandA, operandB);
            m_ready_at = m_cyc + (is_special(op, operandA, operandB) ? 0 : LAT_NORMAL - 1);
          end
        end else if (valid_before && out_ready) begin
          m_pending = 1'b0;
        end
      end
      @(negedge clk);
      model_sync_reset();
      if (checking) begin
        bit exp_valid;
        exp_valid = m_pending && (m_cyc >= m_ready_at);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("in_ready", 32'(in_ready), 32'(!m_pending));
        check("busy", 32'(busy), 32'(m_pending));
        if (exp_valid) check("result", result, m_res);
      end
    end
  end

  // One operation: accept, measure latency, optionally hold the result, then consume.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit chk, input logic [31:0] lit, input int hold);
    int n;
    int lat;
    int lat_exp;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    lat_exp  = is_special(o, a, b) ? LAT_SPECIAL : LAT_NORMAL;
    op       = o;
    operandA = a;
    operandB = b;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    op       = 3'($urandom);
    operandA = $urandom;
    operandB = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    if (chk) check("directed result", result, lit);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op       = 3'($urandom);
      operandA = $urandom;
      operandB = $urandom;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (chk && hold > 0) check("held result", result, lit);
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    check("in_ready after consume", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    rst_cnt   = 0;
    checking  = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    operandA  = '0;
    operandB  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result, 32'd0);
    checking = 1'b1;
    @(posedge clk); #2;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'd100, 32'd7, 1'b1, 32'd14, 0);
    do_op(3'd7, 32'd100, 32'd7, 1'b1, 32'd2, 0);
    do_op(3'd5, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 0);
    do_op(3'd7, 32'h1234, 32'd0, 1'b1, 32'h1234, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 0);
    do_op(3'd0, 32'd5, 32'd6, 1'b1, 32'd30, 20);

    // flush at CALC count 10, with a competing request in the same cycle
    op = 3'd5; operandA = 32'd1000; operandB = 32'd7; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; operandA = 32'd3; operandB = 32'd3;
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush busy", 32'(busy), 32'd0);
    do_op(3'd5, 32'd9, 32'd3, 1'b1, 32'd3, 0);

    // asynchronous reset in the middle of CALC
    op = 3'd4; operandA = 32'd12345; operandB = 32'd17; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    rst_cnt++;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset in_ready", 32'(in_ready), 32'd1);
    check("async reset result", result, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    for (int k = 0; k < 150; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = pick();
      rb = pick();
      do_op(3'($urandom), ra, rb, 1'b0, 32'h0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
